// File: rtl/core_supervisor.sv
// Run control for the matrix-multiplication cores: launches a masked subset together and reports completion.
// Latency: status/busy follow start by 1 cycle; done pulses 1 cycle after the last masked end_process is sampled.
// Backpressure: none; start is only accepted in IDLE and is otherwise dropped, and abort cancels LAUNCH/RUN.
// Optional feature: define CORE_SUPERVISOR_CYCLE_COUNTER_EN to build the RUN-cycle counter behind cycle_count.
module core_supervisor #(
  parameter int NUM_CORES     = 4,
  parameter int LAUNCH_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_CORES-1:0]   core_mask,
  input  logic                   abort,
  input  logic [NUM_CORES-1:0]   end_process,
  output logic [2*NUM_CORES-1:0] status,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_CORES-1:0]   done_flags,
  output logic [31:0]            cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LAUNCH   = 2'd1,
    S_RUN      = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  // Per-core command codes driven on status
  localparam logic [1:0] CMD_HOLD    = 2'b00;
  localparam logic [1:0] CMD_RUN     = 2'b01;
  localparam logic [1:0] CMD_DONE    = 2'b10;
  localparam logic [1:0] CMD_RESTART = 2'b11;

  // Launch counter only needs to reach LAUNCH_CYCLES-1
  localparam int CW = (LAUNCH_CYCLES > 1) ? $clog2(LAUNCH_CYCLES) : 1;
  localparam logic [CW-1:0] LAUNCH_LAST = CW'(LAUNCH_CYCLES - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [NUM_CORES-1:0]     mask_q;
  logic [NUM_CORES-1:0]     mask_nxt;
  logic [NUM_CORES-1:0]     flags_nxt;
  logic [NUM_CORES-1:0]     new_sets;
  logic [CW-1:0]            launch_cnt;
  logic [CW-1:0]            launch_cnt_nxt;
  logic [2*NUM_CORES-1:0]   status_nxt;

  // Next-state, mask and flag update; end_process only counts in RUN on masked cores
  always_comb begin
    state_nxt      = state;
    mask_nxt       = mask_q;
    flags_nxt      = done_flags;
    launch_cnt_nxt = launch_cnt;
    new_sets       = end_process & mask_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          mask_nxt       = core_mask;
          flags_nxt      = '0;
          launch_cnt_nxt = '0;
          state_nxt      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (launch_cnt == LAUNCH_LAST) begin
          state_nxt = S_RUN;
        end else begin
          launch_cnt_nxt = launch_cnt + CW'(1);
        end
      end
      S_RUN: begin
        // Abort wins over completion and leaves the flags exactly as they were
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          flags_nxt = done_flags | new_sets;
          if ((flags_nxt & mask_q) == mask_q) begin
            state_nxt = S_COMPLETE;
          end
        end
      end
      S_COMPLETE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Decode the per-core command from where the FSM is going, so status is registered with the state
  always_comb begin
    status_nxt = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      case (state_nxt)
        S_LAUNCH: status_nxt[2*n +: 2] = mask_nxt[n] ? CMD_RESTART : CMD_HOLD;
        S_RUN: begin
          if (!mask_nxt[n])      status_nxt[2*n +: 2] = CMD_HOLD;
          else if (flags_nxt[n]) status_nxt[2*n +: 2] = CMD_DONE;
          else                   status_nxt[2*n +: 2] = CMD_RUN;
        end
        default: status_nxt[2*n +: 2] = flags_nxt[n] ? CMD_DONE : CMD_HOLD;
      endcase
    end
  end

  // FSM state and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      done_flags <= '0;
      launch_cnt <= '0;
      status     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      mask_q     <= mask_nxt;
      done_flags <= flags_nxt;
      launch_cnt <= launch_cnt_nxt;
      status     <= status_nxt;
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_COMPLETE);
    end
  end

`ifdef CORE_SUPERVISOR_CYCLE_COUNTER_EN
  // Saturating count of RUN cycles; cleared on an accepted start, frozen by abort and outside RUN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state == S_IDLE && start) begin
      cycle_count <= '0;
    end else if (state == S_RUN && !abort && cycle_count != 32'hFFFF_FFFF) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_core_supervisor.sv
module tb_core_supervisor;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] core_mask;
  logic       abort;
  logic [3:0] end_process;
  logic [7:0] status;
  logic       busy;
  logic       done;
  logic [3:0] done_flags;
  logic [31:0] cycle_count;

  int passed;
  int total;

`ifdef CORE_SUPERVISOR_CYCLE_COUNTER_EN
  localparam logic [31:0] EXP_CNT4 = 32'd4;
`else
  localparam logic [31:0] EXP_CNT4 = 32'd0;
`endif

  core_supervisor #(.NUM_CORES(4), .LAUNCH_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .start(start), .core_mask(core_mask),
    .abort(abort), .end_process(end_process), .status(status), .busy(busy),
    .done(done), .done_flags(done_flags), .cycle_count(cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [3:0] m);
    start = 1'b1; core_mask = m;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; core_mask = '0; abort = 1'b0; end_process = '0;
    #12;
    total++; if (status !== 8'h00) $display("FAIL reset_status got=%b exp=%b", status, 8'h00); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); else passed++;
    total++; if (done_flags !== 4'h0 || cycle_count !== 32'd0) $display("FAIL reset_flags_cnt got=%b/%0d exp=0000/0", done_flags, cycle_count); else passed++;
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  task automatic test_launch_run();
    launch(4'b0101);
    total++; if (status !== 8'b00_11_00_11) $display("FAIL launch1_status got=%b exp=%b", status, 8'b00_11_00_11); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL launch1_busy got=%b exp=1", busy); else passed++;
    step();
    total++; if (status !== 8'b00_11_00_11) $display("FAIL launch2_status got=%b exp=%b", status, 8'b00_11_00_11); else passed++;
    step();
    total++; if (status !== 8'b00_01_00_01 || busy !== 1'b1) $display("FAIL run_status got=%b/%b exp=%b/1", status, busy, 8'b00_01_00_01); else passed++;
    end_process = 4'b0001;
    step();
    total++; if (status !== 8'b00_01_00_10 || done_flags !== 4'b0001) $display("FAIL finish0 got=%b/%b exp=%b/0001", status, done_flags, 8'b00_01_00_10); else passed++;
    total++; if (done !== 1'b0) $display("FAIL finish0_done got=%b exp=0", done); else passed++;
    step();
    step();
    end_process = 4'b0101;
    step();
    total++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL complete_done got=%b/%b exp=1/1", done, busy); else passed++;
    total++; if (status !== 8'b00_10_00_10 || done_flags !== 4'b0101) $display("FAIL complete_status got=%b/%b exp=%b/0101", status, done_flags, 8'b00_10_00_10); else passed++;
    total++; if (cycle_count !== EXP_CNT4) $display("FAIL cycle_count got=%0d exp=%0d", cycle_count, EXP_CNT4); else passed++;
    step();
    end_process = 4'b0000;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL idle_after got=%b/%b exp=0/0", done, busy); else passed++;
    total++; if (status !== 8'b00_10_00_10) $display("FAIL idle_status got=%b exp=%b", status, 8'b00_10_00_10); else passed++;
    step();
    total++; if (cycle_count !== EXP_CNT4) $display("FAIL cycle_count_hold got=%0d exp=%0d", cycle_count, EXP_CNT4); else passed++;
  endtask

  task automatic test_all_same_cycle();
    launch(4'b1111);
    total++; if (done_flags !== 4'h0 || status !== 8'hFF) $display("FAIL all_launch got=%b/%h exp=0000/ff", done_flags, status); else passed++;
    step();
    step();
    total++; if (status !== 8'h55) $display("FAIL all_run got=%h exp=55", status); else passed++;
    end_process = 4'b1111;
    step();
    total++; if (done !== 1'b1 || status !== 8'hAA || done_flags !== 4'hF) $display("FAIL all_done got=%b/%h/%b exp=1/aa/1111", done, status, done_flags); else passed++;
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL all_done_pulse got=%b/%b exp=0/0", done, busy); else passed++;
  endtask

  task automatic test_stale_end_process();
    end_process = 4'b0010;
    launch(4'b0010);
    total++; if (done_flags !== 4'h0) $display("FAIL stale_l1 got=%b exp=0000", done_flags); else passed++;
    step();
    total++; if (done_flags !== 4'h0 || status !== 8'b00_00_11_00) $display("FAIL stale_l2 got=%b/%b exp=0000/%b", done_flags, status, 8'b00_00_11_00); else passed++;
    step();
    end_process = 4'b0000;
    total++; if (done_flags !== 4'h0 || status !== 8'b00_00_01_00) $display("FAIL stale_run got=%b/%b exp=0000/%b", done_flags, status, 8'b00_00_01_00); else passed++;
    step();
    total++; if (done_flags[1] !== 1'b0 || done !== 1'b0) $display("FAIL stale_run2 got=%b/%b exp=0/0", done_flags[1], done); else passed++;
    end_process = 4'b0010;
    step();
    total++; if (done !== 1'b1 || done_flags !== 4'b0010) $display("FAIL stale_finish got=%b/%b exp=1/0010", done, done_flags); else passed++;
    end_process = 4'b0000;
    step();
  endtask

  task automatic test_empty_mask();
    launch(4'b0000);
    total++; if (busy !== 1'b1 || status !== 8'h00) $display("FAIL empty_launch got=%b/%h exp=1/00", busy, status); else passed++;
    step();
    step();
    total++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL empty_run got=%b/%b exp=0/1", done, busy); else passed++;
    step();
    total++; if (done !== 1'b1) $display("FAIL empty_done got=%b exp=1", done); else passed++;
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL empty_idle got=%b/%b exp=0/0", done, busy); else passed++;
  endtask

  task automatic test_abort();
    launch(4'b0011);
    step();
    step();
    end_process = 4'b0001;
    step();
    // start while running must be dropped
    start = 1'b1; core_mask = 4'b1100;
    step();
    start = 1'b0;
    total++; if (status !== 8'b00_00_01_10 || done_flags !== 4'b0001) $display("FAIL abort_prerun got=%b/%b exp=%b/0001", status, done_flags, 8'b00_00_01_10); else passed++;
    abort = 1'b1;
    step();
    abort = 1'b0; end_process = 4'b0000;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle got=%b/%b exp=0/0", busy, done); else passed++;
    total++; if (status !== 8'b00_00_00_10 || done_flags !== 4'b0001) $display("FAIL abort_status got=%b/%b exp=%b/0001", status, done_flags, 8'b00_00_00_10); else passed++;
    step();
    total++; if (done !== 1'b0) $display("FAIL abort_no_done got=%b exp=0", done); else passed++;
    // start and abort together in IDLE still launch
    abort = 1'b1;
    launch(4'b0001);
    abort = 1'b0;
    total++; if (busy !== 1'b1 || status !== 8'b00_00_00_11 || done_flags !== 4'h0) $display("FAIL restart got=%b/%b/%b exp=1/%b/0000", busy, status, done_flags, 8'b00_00_00_11); else passed++;
  endtask

  task automatic test_reset_midrun();
    step();
    step();
    total++; if (status !== 8'b00_00_00_01) $display("FAIL midrun_pre got=%b exp=%b", status, 8'b00_00_00_01); else passed++;
    end_process = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    total++; if (status !== 8'h00 || busy !== 1'b0 || done_flags !== 4'h0) $display("FAIL midrun_reset got=%h/%b/%b exp=00/0/0000", status, busy, done_flags); else passed++;
    @(negedge clock);
    reset = 1'b0;
    step();
    total++; if (status !== 8'h00 || busy !== 1'b0) $display("FAIL post_reset got=%h/%b exp=00/0", status, busy); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_launch_run();
    test_all_same_cycle();
    test_stale_end_process();
    test_empty_mask();
    test_abort();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_supervisor.md
# core_supervisor

Run-control block for the matrix-multiplication cores. It drives each core's `status[1:0]` input and collects each core's `end_process` output. Start and completion handshakes go to the host side. It sits beside the cores and memories at the top level, launches a masked subset of cores together, and reports when all of them have finished.

## Interface
Parameters:
- `NUM_CORES`, 4: number of supervised cores.
- `LAUNCH_CYCLES`, 2: number of cycles RESTART is held on launched cores (min 1).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  host launch request, sampled only in IDLE.
- `core_mask`  in  NUM_CORES  cores taking part in the run; sampled when `start` is accepted.
- `abort`  in  1  host cancel.
- `end_process`  in  NUM_CORES  per-core finished level, bit n from core n.
- `status`  out  2*NUM_CORES  per-core command; core n is on bits [2n+1:2n].
- `busy`  out  1  high from LAUNCH through COMPLETE.
- `done`  out  1  one-cycle pulse when all masked cores have finished.
- `done_flags`  out  NUM_CORES  sticky per-core finished flags.
- `cycle_count`  out  32  RUN-cycle count (see Configuration).

## Operation
- Status codes:
  - 2'b00 HOLD: core idles.
  - 2'b01 RUN: core executes.
  - 2'b10 DONE: finish acknowledged, core parks.
  - 2'b11 RESTART: core resets its PC and its `end_process`.
- States: IDLE, LAUNCH, RUN, COMPLETE.
- IDLE:
  - `start`=1 latches `core_mask` into `mask_q`, clears `done_flags` and the launch counter, then goes to LAUNCH.
  - Outside a run, status[n] is DONE if done_flags[n] is set, else HOLD.
- LAUNCH:
  - Masked cores get RESTART; unmasked cores get HOLD.
  - Lasts exactly LAUNCH_CYCLES cycles, then goes to RUN.
  - `end_process` is ignored in this state, so stale levels from the previous run are discarded.
- RUN:
  - Masked core with done_flags[n]=0 gets RUN.
  - Masked core with done_flags[n]=1 gets DONE.
  - Unmasked core gets HOLD.
  - `end_process[n]`=1 with mask_q[n]=1 sets done_flags[n].
  - Moves to COMPLETE when `(done_flags | new_sets) & mask_q == mask_q`. Several cores finishing in the same cycle all count.
- COMPLETE:
  - Lasts one cycle, with `done`=1 and status unchanged (DONE or HOLD).
  - Then goes to IDLE.
- Empty mask: `mask_q`==0 still passes through LAUNCH (all HOLD). RUN then exits after its first cycle, so `done` pulses at start+LAUNCH_CYCLES+2.
- Ignored inputs:
  - `end_process` on an unmasked core, or in IDLE, LAUNCH or COMPLETE, is ignored.
  - `start` outside IDLE is ignored.
- `abort`:
  - Applies in LAUNCH or RUN; it has priority over the completion check.
  - Next state is IDLE with no `done` pulse; done_flags are kept as-is.
  - In IDLE and COMPLETE, `abort` is ignored.
- `start` and `abort` both high in IDLE: the launch proceeds.

## Timing
- Reset values:
  - state IDLE
  - `status` all 2'b00
  - `busy`=0, `done`=0
  - `done_flags`=0, `mask_q`=0
  - `cycle_count`=0
- All outputs are registered. `status` is a registered decode of the next state and flags.
- Launch: `start` high at edge T gives LAUNCH (status 11, busy=1) from T+1 through T+LAUNCH_CYCLES. RUN (status 01) begins at T+LAUNCH_CYCLES+1.
- Finish: `end_process[n]` sampled high at edge E gives done_flags[n]=1 and status[n]=10 from E+1.
- Completion: if the last masked finish is at edge E, COMPLETE and `done`=1 occupy E+1. At E+2 the state is IDLE with `busy`=0.
- Reset mid-run: everything returns to reset values immediately (asynchronous). All cores see HOLD.

## Configuration
- `CORE_SUPERVISOR_CYCLE_COUNTER_EN` defined:
  - `cycle_count` clears when `start` is accepted.
  - It increments on every cycle spent in RUN and saturates at 32'hFFFF_FFFF.
  - It holds its value in IDLE until the next accepted start; abort also freezes it.
- Undefined: no counter logic is built; `cycle_count` is constant 0.

## Test plan
- Reset, then start with mask=4'b0101 and LAUNCH_CYCLES=2 -> status=8'b00_11_00_11 for 2 cycles, then 8'b00_01_00_01; busy=1.
- In RUN, raise end_process[0], then end_process[2] three cycles later -> status[1:0]=10 first, then `done` pulse 1 cycle after the second finish; done_flags=0101; cycle_count=4 with macro, 0 without.
- Mask=4'b1111 with all four end_process rising in the same cycle -> `done` pulses on the next cycle only; status=8'hAA.
- Hold end_process[1]=1 from the previous run through the new LAUNCH, then drop it -> no flag is set during LAUNCH; done_flags[1] stays 0.
- Abort at the 3rd RUN cycle with mask=4'b0011 and core 0 already finished -> IDLE next cycle with no `done`; status=8'b00_00_00_10; start is accepted again afterwards.
- Assert `reset` mid-RUN -> status=0, busy=0, done_flags=0 before the next clock edge.
